// File: rtl/jtag_pkg.sv
// jtag_pkg
//   Shared definitions for the JTAG TAP target and its FSM.
//   - tap_state_t : 4-bit IEEE 1149.1 TAP state encoding (also used by the
//                   engine that drives this target).
//   - IDCODE / USER / BYPASS : instruction codes.
//   - IR_CAPTURE  : fixed pattern loaded into the IR in Capture-IR.
//   - dr_sel_t    : which data register the current instruction selects.
package jtag_pkg;

   typedef enum logic [3:0] {
      TLR    = 4'h0,
      RTI    = 4'h1,
      SEL_DR = 4'h2,
      CAP_DR = 4'h3,
      SH_DR  = 4'h4,
      EX1_DR = 4'h5,
      PAU_DR = 4'h6,
      EX2_DR = 4'h7,
      UPD_DR = 4'h8,
      SEL_IR = 4'h9,
      CAP_IR = 4'hA,
      SH_IR  = 4'hB,
      EX1_IR = 4'hC,
      PAU_IR = 4'hD,
      EX2_IR = 4'hE,
      UPD_IR = 4'hF
   } tap_state_t;

   localparam logic [3:0] IDCODE     = 4'h1;
   localparam logic [3:0] USER       = 4'h2;
   localparam logic [3:0] BYPASS     = 4'hF;
   localparam logic [3:0] IR_CAPTURE = 4'b0101;

   typedef enum logic [1:0] {
      DR_BYPASS = 2'd0,
      DR_IDCODE = 2'd1,
      DR_USER   = 2'd2
   } dr_sel_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm
//   IEEE 1149.1 16-state TAP controller. Advances one state per qualified
//   TCK rising edge using the (already synchronised) TMS value.
//   Ports:
//     clk     - system clock
//     rst     - asynchronous active-low reset (forces TLR)
//     i_adv   - one-clk strobe: a TCK rising edge was detected
//     i_tms   - synchronised TMS
//     o_state - current TAP state (registered)
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_adv,
   input  logic       i_tms,
   output tap_state_t o_state
);

   tap_state_t r_state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= TLR;
      end else if (i_adv) begin
         case (r_state)
            TLR:     r_state <= i_tms ? TLR    : RTI;
            RTI:     r_state <= i_tms ? SEL_DR : RTI;
            SEL_DR:  r_state <= i_tms ? SEL_IR : CAP_DR;
            CAP_DR:  r_state <= i_tms ? EX1_DR : SH_DR;
            SH_DR:   r_state <= i_tms ? EX1_DR : SH_DR;
            EX1_DR:  r_state <= i_tms ? UPD_DR : PAU_DR;
            PAU_DR:  r_state <= i_tms ? EX2_DR : PAU_DR;
            EX2_DR:  r_state <= i_tms ? UPD_DR : SH_DR;
            UPD_DR:  r_state <= i_tms ? SEL_DR : RTI;
            SEL_IR:  r_state <= i_tms ? TLR    : CAP_IR;
            CAP_IR:  r_state <= i_tms ? EX1_IR : SH_IR;
            SH_IR:   r_state <= i_tms ? EX1_IR : SH_IR;
            EX1_IR:  r_state <= i_tms ? UPD_IR : PAU_IR;
            PAU_IR:  r_state <= i_tms ? EX2_IR : PAU_IR;
            EX2_IR:  r_state <= i_tms ? UPD_IR : SH_IR;
            UPD_IR:  r_state <= i_tms ? SEL_DR : RTI;
            default: r_state <= TLR;
         endcase
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/jtag_tap_target.sv
// jtag_tap_target
//   JTAG TAP responder clocked entirely by the system clock. TCK/TMS/TDI are
//   oversampled through 2-FF synchronisers; a third TCK flop yields rise/fall
//   strobes that drive the TAP FSM, the IR and the IDCODE/USER/BYPASS data
//   registers.
//   Ports:
//     clk, rst        - system clock, asynchronous active-low reset
//     TCK, TMS, TDI   - JTAG pins (asynchronous to clk)
//     TDO, tdo_en     - JTAG data out and its enable (Shift-IR/Shift-DR only)
//     user_data_in    - value captured into USER in Capture-DR
//     user_data_out   - last value shifted in under USER, written in Update-DR
//     user_update     - one-clk pulse when user_data_out is written
//     tap_state       - current TAP state (debug)
//     ir_out          - current instruction
module jtag_tap_target
   import jtag_pkg::*;
#(
   parameter int          IR_LEN       = 4,
   parameter logic [31:0] IDCODE_VALUE = 32'h4A54_0001,
   parameter int          USER_LEN     = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                TCK,
   input  logic                TMS,
   input  logic                TDI,
   output logic                TDO,
   output logic                tdo_en,
   input  logic [USER_LEN-1:0] user_data_in,
   output logic [USER_LEN-1:0] user_data_out,
   output logic                user_update,
   output logic [3:0]          tap_state,
   output logic [IR_LEN-1:0]   ir_out
);

   logic [1:0]          r_tck_sync, r_tms_sync, r_tdi_sync;
   logic                r_tck_prev;
   logic [IR_LEN-1:0]   r_ir, r_ir_sr;
   logic [31:0]         r_idcode_sr;
   logic [USER_LEN-1:0] r_user_sr, r_user_out;
   logic                r_bypass_sr;
   logic                r_tdo, r_user_update;

   logic       w_tck_rise, w_tck_fall, w_tms, w_tdi, w_shift, w_dr_lsb;
   tap_state_t w_state;
   dr_sel_t    w_dr_sel;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tck_sync <= '0;
         r_tms_sync <= '0;
         r_tdi_sync <= '0;
         r_tck_prev <= 1'b0;
      end else begin
         r_tck_sync <= {r_tck_sync[0], TCK};
         r_tms_sync <= {r_tms_sync[0], TMS};
         r_tdi_sync <= {r_tdi_sync[0], TDI};
         r_tck_prev <= r_tck_sync[1];
      end
   end

   assign w_tck_rise = r_tck_sync[1] & ~r_tck_prev;
   assign w_tck_fall = ~r_tck_sync[1] & r_tck_prev;
   assign w_tms      = r_tms_sync[1];
   assign w_tdi      = r_tdi_sync[1];

   jtag_tap_fsm u_fsm (
      .clk     (clk),
      .rst     (rst),
      .i_adv   (w_tck_rise),
      .i_tms   (w_tms),
      .o_state (w_state)
   );

   // Any code other than IDCODE/USER falls back to BYPASS.
   always_comb begin
      w_dr_sel = DR_BYPASS;
      if (r_ir == IR_LEN'(IDCODE))
         w_dr_sel = DR_IDCODE;
      else if (r_ir == IR_LEN'(USER))
         w_dr_sel = DR_USER;
   end

   always_comb begin
      w_dr_lsb = r_bypass_sr;
      case (w_dr_sel)
         DR_IDCODE: w_dr_lsb = r_idcode_sr[0];
         DR_USER:   w_dr_lsb = r_user_sr[0];
         default:   w_dr_lsb = r_bypass_sr;
      endcase
   end

   assign w_shift = (w_state == SH_DR) || (w_state == SH_IR);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ir          <= IR_LEN'(IDCODE);
         r_ir_sr       <= '0;
         r_idcode_sr   <= '0;
         r_user_sr     <= '0;
         r_user_out    <= '0;
         r_bypass_sr   <= 1'b0;
         r_tdo         <= 1'b0;
         r_user_update <= 1'b0;
      end else begin
         r_user_update <= 1'b0;

         if (w_state == TLR)
            r_ir <= IR_LEN'(IDCODE);

         // Capture/shift act on the state being left at this TCK rise.
         if (w_tck_rise) begin
            case (w_state)
               CAP_IR: r_ir_sr <= IR_LEN'(IR_CAPTURE);
               SH_IR:  r_ir_sr <= {w_tdi, r_ir_sr[IR_LEN-1:1]};
               CAP_DR: begin
                  case (w_dr_sel)
                     DR_IDCODE: r_idcode_sr <= IDCODE_VALUE;
                     DR_USER:   r_user_sr   <= user_data_in;
                     default:   r_bypass_sr <= 1'b0;
                  endcase
               end
               SH_DR: begin
                  case (w_dr_sel)
                     DR_IDCODE: r_idcode_sr <= {w_tdi, r_idcode_sr[31:1]};
                     DR_USER:   r_user_sr   <= {w_tdi, r_user_sr[USER_LEN-1:1]};
                     default:   r_bypass_sr <= w_tdi;
                  endcase
               end
               default: ;
            endcase
         end

         if (w_tck_fall) begin
            case (w_state)
               SH_IR:  r_tdo <= r_ir_sr[0];
               SH_DR:  r_tdo <= w_dr_lsb;
               UPD_IR: r_ir  <= r_ir_sr;
               UPD_DR: begin
                  if (w_dr_sel == DR_USER) begin
                     r_user_out    <= r_user_sr;
                     r_user_update <= 1'b1;
                  end
               end
               default: ;
            endcase
         end

         // Stale shift data must not reappear on the next entry to a shift state.
         if (!w_shift)
            r_tdo <= 1'b0;
      end
   end

   assign TDO           = r_tdo & w_shift;
   assign tdo_en        = w_shift;
   assign user_data_out = r_user_out;
   assign user_update   = r_user_update;
   assign tap_state     = w_state;
   assign ir_out        = r_ir;

endmodule

// File: tb/tb_jtag_tap_target.sv
`timescale 1ns/1ps
module tb_jtag_tap_target;
   import jtag_pkg::*;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        TCK = 1'b0;
   logic        TMS = 1'b1;
   logic        TDI = 1'b0;
   logic        TDO, tdo_en, user_update;
   logic [31:0] user_data_in = '0;
   logic [31:0] user_data_out;
   logic [3:0]  tap_state;
   logic [3:0]  ir_out;

   always #50 clk = ~clk;   // 10 MHz

   jtag_tap_target dut (
      .clk           (clk),
      .rst           (rst),
      .TCK           (TCK),
      .TMS           (TMS),
      .TDI           (TDI),
      .TDO           (TDO),
      .tdo_en        (tdo_en),
      .user_data_in  (user_data_in),
      .user_data_out (user_data_out),
      .user_update   (user_update),
      .tap_state     (tap_state),
      .ir_out        (ir_out)
   );

   // ---------------- scoreboard ----------------
   int          tests = 0;
   int          fails = 0;
   int          upd_count = 0;
   logic [31:0] exp_q[$];

   always @(posedge clk) if (user_update) upd_count++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // One full TCK period: setup 4 clk, high 6 clk, low 6 clk.
   task automatic tck(input logic tms, input logic tdi);
      @(negedge clk);
      TMS = tms;
      TDI = tdi;
      repeat (4) @(negedge clk);
      TCK = 1'b1;
      repeat (6) @(negedge clk);
      TCK = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   // Samples TDO before each rise; leaves Shift on the last bit if exit_last.
   task automatic shift_bits(input int n, input logic [31:0] din, input logic exit_last,
                             output logic [31:0] dout);
      dout = '0;
      for (int i = 0; i < n; i++) begin
         dout[i] = TDO;
         tck(exit_last && (i == n - 1), din[i]);
      end
   endtask

   task automatic rti_to_shdr();
      tck(1'b1, 1'b0);
      tck(1'b0, 1'b0);
      tck(1'b0, 1'b0);
   endtask

   task automatic rti_to_shir();
      tck(1'b1, 1'b0);
      tck(1'b1, 1'b0);
      tck(1'b0, 1'b0);
      tck(1'b0, 1'b0);
   endtask

   // From Exit1: Update then Run-Test/Idle.
   task automatic exit_to_rti();
      tck(1'b1, 1'b0);
      tck(1'b0, 1'b0);
   endtask

   task automatic load_ir(input logic [3:0] code, input string tag);
      logic [31:0] cap;
      rti_to_shir();
      shift_bits(4, {28'h0, code}, 1'b1, cap);
      check({tag, "_ir_capture"}, cap, 32'h0000_0005);
      exit_to_rti();
      check({tag, "_ir_out"}, {28'h0, ir_out}, {28'h0, code});
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   logic [31:0] cap, cap_lo, cap_hi;

   initial begin
      repeat (5) @(negedge clk);
      check("rst_state",    {28'h0, tap_state}, {28'h0, TLR});
      check("rst_ir_out",   {28'h0, ir_out},    32'h1);
      check("rst_tdo",      {31'h0, TDO},       32'h0);
      check("rst_tdo_en",   {31'h0, tdo_en},    32'h0);
      check("rst_update",   {31'h0, user_update}, 32'h0);
      check("rst_user_out", user_data_out,      32'h0);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // 5 x TMS=1 keeps/returns TLR
      repeat (5) tck(1'b1, 1'b0);
      check("tlr_after_5", {28'h0, tap_state}, {28'h0, TLR});
      tck(1'b0, 1'b0);
      check("rti", {28'h0, tap_state}, {28'h0, RTI});

      // IDCODE read
      rti_to_shdr();
      check("shdr_state",  {28'h0, tap_state}, {28'h0, SH_DR});
      check("shdr_tdo_en", {31'h0, tdo_en}, 32'h1);
      shift_bits(32, 32'h0, 1'b1, cap);
      check("ex1_tdo_en", {31'h0, tdo_en}, 32'h0);
      exit_to_rti();
      check("idcode", cap, 32'h4A54_0001);
      check("idcode_ir_out", {28'h0, ir_out}, 32'h1);

      // IR capture and USER write/read
      load_ir(4'h2, "user");
      user_data_in = 32'hCAFE_F00D;
      rti_to_shdr();
      shift_bits(32, 32'h1234_5678, 1'b1, cap);
      check("user_tdo", cap, 32'hCAFE_F00D);
      check("user_no_early_upd", upd_count, 0);
      check("user_out_before_upd", user_data_out, 32'h0);
      tck(1'b1, 1'b0);
      check("user_upd_state", {28'h0, tap_state}, {28'h0, UPD_DR});
      check("user_data_out", user_data_out, 32'h1234_5678);
      check("user_upd_pulses", upd_count, 1);
      tck(1'b0, 1'b0);

      // BYPASS with an unassigned code
      load_ir(4'h7, "byp");
      rti_to_shdr();
      cap = 32'h0000_00B3;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back((i == 0) ? 32'h0 : {31'h0, cap[i-1]});
         check("bypass_tdo", {31'h0, TDO}, exp_q.pop_front());
         tck(i == 7, cap[i]);
      end
      exit_to_rti();

      // 5 x TMS=1 from Shift-DR reaches TLR and reloads IDCODE
      rti_to_shdr();
      repeat (5) tck(1'b1, 1'b0);
      check("tlr_from_shdr", {28'h0, tap_state}, {28'h0, TLR});
      check("tlr_ir_out", {28'h0, ir_out}, 32'h1);
      tck(1'b0, 1'b0);

      // Pause/resume during a USER shift
      load_ir(4'h2, "pause");
      user_data_in = 32'hA5C3_3C5A;
      rti_to_shdr();
      shift_bits(16, 32'h0000_2D3C, 1'b1, cap_lo);
      check("pause_ex1", {28'h0, tap_state}, {28'h0, EX1_DR});
      tck(1'b0, 1'b0);
      repeat (10) tck(1'b0, 1'b1);
      check("pause_pau", {28'h0, tap_state}, {28'h0, PAU_DR});
      tck(1'b1, 1'b0);
      tck(1'b0, 1'b0);
      check("pause_resume", {28'h0, tap_state}, {28'h0, SH_DR});
      shift_bits(16, 32'h0000_0F1E, 1'b1, cap_hi);
      check("pause_tdo", {cap_hi[15:0], cap_lo[15:0]}, 32'hA5C3_3C5A);
      tck(1'b1, 1'b0);
      check("pause_user_out", user_data_out, 32'h0F1E_2D3C);
      check("pause_upd_pulses", upd_count, 2);
      tck(1'b0, 1'b0);

      // Asynchronous reset mid-shift
      rti_to_shdr();
      shift_bits(10, 32'h0000_03FF, 1'b0, cap);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("arst_state",    {28'h0, tap_state}, {28'h0, TLR});
      check("arst_user_out", user_data_out, 32'h0);
      check("arst_tdo_en",   {31'h0, tdo_en}, 32'h0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      check("arst_no_upd", upd_count, 2);
      check("arst_ir_out", {28'h0, ir_out}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/jtag_tap_target.md
# jtag_tap_target

JTAG TAP responder: the target end of the link that `jtag_engine_simple` drives. It oversamples TCK, TMS and TDI on the system clock and runs the IEEE 1149.1 16-state TAP controller. It provides a 4-bit IR, a 32-bit IDCODE register, a 1-bit BYPASS register and a 32-bit USER data register with capture and update hooks. It serves as the in-fabric loopback target for the UART-to-JTAG bridge and as the reference responder in bridge simulations.

## Interface
- `IR_LEN`, 4: instruction register width; matches the 4-bit command instruction field.
- `IDCODE_VALUE`, 32'h4A54_0001: value loaded in Capture-DR under IDCODE; bit 0 must be 1.
- `USER_LEN`, 32: USER data register width.
- `clk`  in  1  system clock (10 MHz); the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `TCK`  in  1  JTAG clock, asynchronous to `clk`.
- `TMS`  in  1  JTAG mode select.
- `TDI`  in  1  JTAG data in.
- `TDO`  out  1  JTAG data out.
- `tdo_en`  out  1  high while in Shift-IR or Shift-DR.
- `user_data_in`  in  USER_LEN  value captured into USER in Capture-DR.
- `user_data_out`  out  USER_LEN  last value shifted in under USER.
- `user_update`  out  1  one-`clk` pulse when `user_data_out` is written.
- `tap_state`  out  4  current TAP state, for debug.
- `ir_out`  out  IR_LEN  current instruction.

## Operation
- **Input synchronisation:** TCK, TMS and TDI each pass through a 2-FF synchroniser. A third TCK flop detects edges.
  - `tck_rise` = sync high and previous low.
  - `tck_fall` = sync low and previous high.
- **TAP FSM:** standard 16 states: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, and the same set for IR.
  - The FSM advances only on `tck_rise`, using synchronised TMS.
  - Five consecutive `tck_rise` with TMS=1 reach TLR from any state.
- **Instructions:**
  - IDCODE = 4'h1. Selects the 32-bit IDCODE register.
  - USER = 4'h2. Selects the USER register.
  - BYPASS = 4'hF, and any other code. Selects the 1-bit BYPASS register, which captures 0.
  - Entering TLR loads IDCODE into the IR.
- **Actions on `tck_rise`, by state:**
  - CAP_IR: the IR shift register loads 4'b0101.
  - SH_IR: `ir_sr <= {TDI, ir_sr[IR_LEN-1:1]}`.
  - CAP_DR: the selected DR shift register loads IDCODE_VALUE, `user_data_in`, or 0.
  - SH_DR: the selected DR shifts right, with TDI entering the MSB.
- **Actions on `tck_fall`, by state:**
  - SH_IR / SH_DR: `TDO <= sr[0]` of the active register.
  - UPD_IR: `ir_out <= ir_sr`.
  - UPD_DR with USER selected: `user_data_out <= user_sr`, and `user_update` pulses for exactly one `clk`.
- **Outside shift states:** `TDO` is held at 0 and `tdo_en` is 0.

## Timing
- **Reset values:**
  - `tap_state` = TLR.
  - `ir_out` = 4'h1.
  - `TDO`, `tdo_en`, `user_update` = 0.
  - `user_data_out` = 0.
  - Synchroniser flops = 0.
- **Edge latency:** the FSM and shift-register update happen 3 `clk` cycles after a TCK pin edge; `TDO` updates 3 `clk` cycles after a TCK falling edge.
- **TCK limits:** TCK high and low phases must each be at least 4 `clk` cycles. Narrower pulses are out of spec; behaviour for them is undefined but must never wedge the FSM.
- **Setup/hold:** TMS and TDI must be stable for at least 3 `clk` cycles before a TCK rising edge and hold for at least 1 cycle after it.
- **Shift direction:** LSB first. The first TDO bit after CAP→SH is the LSB of the captured value.
- **Mid-operation reset:** asserting `rst` during a shift returns to TLR immediately. The partial shift is discarded and `user_data_out` is cleared.
- **TCK idle:** if TCK stops, every register holds its value.

## Structure
- Package `jtag_pkg` holds:
  - the `tap_state_t` enum (4-bit, shared with `jtag_engine_simple`);
  - the instruction localparams IDCODE, USER and BYPASS;
  - IR_CAPTURE = 4'b0101.
- Sub-module `jtag_tap_fsm` contains the next-state logic plus the state register, and exposes the state enum. Synchronisers and shift registers stay in the top.

## Test plan
- **Reset then IDCODE read:** reset, then 5×TMS=1, then TLR→SH_DR and shift 32 bits of TDI=0. TDO returns 32'h4A54_0001, LSB first, and `ir_out` = 4'h1.
- **IR capture:** load IR 4'h2 while shifting. TDO emits 0101 (LSB first: 1,0,1,0). After UPD_IR, `ir_out` = 4'h2.
- **USER write/read:** with USER selected, set `user_data_in` = 32'hCAFE_F00D and shift in 32'h1234_5678. TDO returns CAFEF00D. On UPD_DR, `user_update` pulses once and `user_data_out` = 32'h1234_5678.
- **BYPASS:** IR = 4'h7, then shift 8 bits 10110011. TDO is the 1-cycle-delayed TDI stream, preceded by a leading 0.
- **Pause/resume:** during a USER shift, go SH_DR→EX1→PAU (held 10 TCK)→EX2→SH_DR and finish. Data is intact with no extra shifts.
- **Async reset mid-shift:** assert `rst` low after 10 bits of a USER shift. `tap_state` = TLR and `user_data_out` = 0 on the same cycle, and `user_update` never pulses.
